rx_serial_8o1: RTL

Serial receiver for 8O1 asynchronous frames: one start bit (0), eight data bits LSB first, one odd-parity bit and one stop bit (1), with the line idle at 1. It sits directly downstream of the 8O1 serial transmitter and consumes its `saida_serial` line. It delivers the received byte with status flags and a one-cycle completion pulse. The block is a control FSM driving a datapath of a bit-timing counter, a bit counter and a shift register.

---
 rtl/rx_serial_pkg.sv | 16 +
 rtl/rx_serial_8o1_fd.sv | 110 +++++++++++
 rtl/rx_serial_8o1.sv | 121 ++++++++++++
 3 files changed

// File: rtl/rx_serial_pkg.sv
// Shared types and frame constants for the 8O1 serial receiver.
package rx_serial_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned FRAME_LEN = 11;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_START    = 4'd1,
    ST_DADOS    = 4'd2,
    ST_PARIDADE = 4'd3,
    ST_STOP     = 4'd4,
    ST_FINAL    = 4'd5
  } state_t;

endpackage

// File: rtl/rx_serial_8o1_fd.sv
// Datapath of the 8O1 receiver: tick and bit counters, shift register,
// parity check and the registered byte/status outputs.
module rx_serial_8O1_fd
  import rx_serial_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rxd,
  input  logic                 recebe,
  input  logic                 tick_clr,
  input  logic                 shift_en,
  input  logic                 bit_clr,
  input  logic                 par_ld,
  input  logic                 final_ld,
  output logic                 tick_half_c,
  output logic                 tick_full_c,
  output logic                 bit_last_c,
  output logic [DATA_BITS-1:0] dados_ascii,
  output logic                 pronto,
  output logic                 tem_dado,
  output logic                 erro_paridade,
  output logic                 erro_stop,
  output logic                 erro_overrun
);

  localparam int unsigned TW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW   = $clog2(DATA_BITS + 1);
  localparam int unsigned HALF = CLKS_PER_BIT / 2;

  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [DATA_BITS-1:0] dados_q, dados_d;
  logic                 pronto_q, pronto_d;
  logic                 tem_q, tem_d;
  logic                 ep_q, ep_d;
  logic                 es_q, es_d;
  logic                 eo_q, eo_d;

  assign tick_half_c = (tick_q == TW'(HALF - 1));
  assign tick_full_c = (tick_q == TW'(CLKS_PER_BIT - 1));
  assign bit_last_c  = (bit_cnt_q == BW'(DATA_BITS - 1));

  // Status registers load at the stop-bit sample so they are valid during FINAL.
  always_comb begin
    tick_d    = tick_clr ? '0 : tick_q + TW'(1);
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    dados_d   = dados_q;
    pronto_d  = final_ld;
    tem_d     = tem_q;
    ep_d      = ep_q;
    es_d      = es_q;
    eo_d      = eo_q;

    if (bit_clr)       bit_cnt_d = '0;
    else if (shift_en) bit_cnt_d = bit_cnt_q + BW'(1);

    if (shift_en) shift_d = {rxd, shift_q[DATA_BITS-1:1]};
    if (par_ld)   par_d   = rxd;

    if (final_ld) begin
      dados_d = shift_q;
      ep_d    = ~(^{shift_q, par_q});
      es_d    = ~rxd;
      eo_d    = tem_q & ~recebe;
      tem_d   = 1'b1;
    end else if (recebe) begin
      tem_d   = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tick_q    <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      dados_q   <= '0;
      pronto_q  <= 1'b0;
      tem_q     <= 1'b0;
      ep_q      <= 1'b0;
      es_q      <= 1'b0;
      eo_q      <= 1'b0;
    end else begin
      tick_q    <= tick_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      dados_q   <= dados_d;
      pronto_q  <= pronto_d;
      tem_q     <= tem_d;
      ep_q      <= ep_d;
      es_q      <= es_d;
      eo_q      <= eo_d;
    end
  end

  assign dados_ascii   = dados_q;
  assign pronto        = pronto_q;
  assign tem_dado      = tem_q;
  assign erro_paridade = ep_q;
  assign erro_stop     = es_q;
  assign erro_overrun  = eo_q;

endmodule

// File: rtl/rx_serial_8o1.sv
// 8O1 serial receiver top: control FSM plus optional input synchronizer.
// Define RX_SERIAL_SYNC_EN to add a 2-flop synchronizer on dado_serial.
module rx_serial_8o1
  import rx_serial_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 dado_serial,
  input  logic                 recebe,
  output logic [DATA_BITS-1:0] dados_ascii,
  output logic                 pronto,
  output logic                 tem_dado,
  output logic                 erro_paridade,
  output logic                 erro_stop,
  output logic                 erro_overrun,
  output logic [3:0]           db_estado
);

  logic   rxd;
  state_t state_q, state_d;
  logic   tick_clr, shift_en, bit_clr, par_ld, final_ld;
  logic   tick_half_c, tick_full_c, bit_last_c;

`ifdef RX_SERIAL_SYNC_EN
  logic [1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[0], dado_serial};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) sync_q <= 2'b11;
    else        sync_q <= sync_d;
  end

  assign rxd = sync_q[1];
`else
  assign rxd = dado_serial;
`endif

  // Every sample point clears the tick counter so the next bit is timed from it.
  always_comb begin
    state_d  = state_q;
    tick_clr = 1'b0;
    shift_en = 1'b0;
    bit_clr  = 1'b0;
    par_ld   = 1'b0;
    final_ld = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        tick_clr = 1'b1;
        bit_clr  = 1'b1;
        if (!rxd) state_d = ST_START;
      end
      ST_START: begin
        bit_clr = 1'b1;
        if (tick_half_c) begin
          tick_clr = 1'b1;
          state_d  = rxd ? ST_IDLE : ST_DADOS;
        end
      end
      ST_DADOS: begin
        if (tick_full_c) begin
          tick_clr = 1'b1;
          shift_en = 1'b1;
          if (bit_last_c) state_d = ST_PARIDADE;
        end
      end
      ST_PARIDADE: begin
        if (tick_full_c) begin
          tick_clr = 1'b1;
          par_ld   = 1'b1;
          state_d  = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick_full_c) begin
          tick_clr = 1'b1;
          final_ld = 1'b1;
          state_d  = ST_FINAL;
        end
      end
      ST_FINAL: begin
        tick_clr = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  assign db_estado = state_q;

  rx_serial_8O1_fd #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_fd (
    .clock         (clock),
    .reset         (reset),
    .rxd           (rxd),
    .recebe        (recebe),
    .tick_clr      (tick_clr),
    .shift_en      (shift_en),
    .bit_clr       (bit_clr),
    .par_ld        (par_ld),
    .final_ld      (final_ld),
    .tick_half_c   (tick_half_c),
    .tick_full_c   (tick_full_c),
    .bit_last_c    (bit_last_c),
    .dados_ascii   (dados_ascii),
    .pronto        (pronto),
    .tem_dado      (tem_dado),
    .erro_paridade (erro_paridade),
    .erro_stop     (erro_stop),
    .erro_overrun  (erro_overrun)
  );

endmodule
